// File: rtl/blackjack_timer_pkg.sv
// Shared types for the game-phase countdown timer.
package blackjack_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int SIM_PRESCALE = 4;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int PRE_W    = $clog2(PRESCALE)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with one-cycle done pulse.
// Optional AUTO_RELOAD_EN: periodic reload from the last accepted start.
module countdown_timer
    import blackjack_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = $clog2(PRESCALE);

    timer_state_t     state_q;
    timer_state_t     state_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             done_q;
    logic             done_d;
    logic             clear;
    logic             enable;
    logic             tick;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
`endif

    assign enable = (state_q == RUN) && !pause;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        done_d  = 1'b0;
        clear   = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (abort) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else if (start) begin
            clear   = 1'b1;
            value_d = load_value;
`ifdef AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            if (load_value == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            // zero is checked before decrementing so value never wraps
            if (tick) begin
                if (value_q <= WIDTH'(1)) begin
                    done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                    value_d = reload_q;
`else
                    value_d = '0;
                    state_d = DONE;
`endif
                end else begin
                    value_d = value_q - 1'b1;
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign value = value_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule
